// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative multiply/divide unit for the EX stage.
// Takes one result bit per cycle. busy_o stalls IF/ID and ID/EX while an op is in flight.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset
//   start_i        op request from ID/EX; sampled only when idle
//   op_i           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   operand_a_i    rs: multiplicand / dividend
//   operand_b_i    rt: multiplier / divisor
//   busy_o         high while an op is in flight
//   done_o         one-cycle pulse; hi_o/lo_o were updated this cycle
//   hi_o           MULT: upper product half; DIV: remainder
//   lo_o           MULT: lower product half; DIV: quotient
//   div_by_zero_o  valid with done_o; divide had a zero divisor
module ex_muldiv_unit #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [Width-1:0] operand_a_i,
    input  logic [Width-1:0] operand_b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [Width-1:0] hi_o,
    output logic [Width-1:0] lo_o,
    output logic             div_by_zero_o
);

    localparam int unsigned     CntW    = (Width > 1) ? $clog2(Width) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(Width - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic                 sign_a_q, sign_a_d;
    logic                 sign_b_q, sign_b_d;
    logic [Width-1:0]     a_q, a_d;
    logic [Width-1:0]     b_q, b_d;
    logic [2*Width-1:0]   acc_q, acc_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [Width-1:0]     hi_q, hi_d;
    logic [Width-1:0]     lo_q, lo_d;
    logic                 dbz_q, dbz_d;
    logic                 done_q, done_d;

    // op_i[1] selects divide, op_i[0] selects unsigned.
    logic             start_signed;
    logic             start_sign_a, start_sign_b;
    logic [Width-1:0] start_mag_a, start_mag_b;

    assign start_signed = ~op_i[0];
    assign start_sign_a = start_signed & operand_a_i[Width-1];
    assign start_sign_b = start_signed & operand_b_i[Width-1];
    assign start_mag_a  = start_sign_a ? -operand_a_i : operand_a_i;
    assign start_mag_b  = start_sign_b ? -operand_b_i : operand_b_i;

    // Multiply: MSB-first shift-add; b_q is shifted left so its top bit is the current digit.
    logic [2*Width-1:0] mul_step;
    assign mul_step = {acc_q[2*Width-2:0], 1'b0} +
                      (b_q[Width-1] ? {{Width{1'b0}}, a_q} : {(2*Width){1'b0}});

    // Divide: acc_q = {remainder, quotient}; a_q supplies dividend bits MSB first.
    // The partial remainder stays below the divisor, so Width+1 bits hold the shifted value.
    // A zero divisor always "subtracts", which leaves quotient all ones and remainder = a.
    logic [Width:0] rem_shift, rem_diff;
    assign rem_shift = {acc_q[2*Width-1:Width], a_q[Width-1]};
    assign rem_diff  = rem_shift - {1'b0, b_q};

    logic [2*Width-1:0] prod_neg;
    logic [Width-1:0]   quo, rem;
    logic               res_neg;
    assign prod_neg = -acc_q;
    assign quo      = acc_q[Width-1:0];
    assign rem      = acc_q[2*Width-1:Width];
    assign res_neg  = sign_a_q ^ sign_b_q;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_i) state_d = StRun;
            StRun:   if (cnt_q == LastCnt) state_d = StFix;
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        busy_o        = (state_q != StIdle);
        done_o        = done_q;
        hi_o          = hi_q;
        lo_o          = lo_q;
        div_by_zero_o = dbz_q;
    end

    // Datapath next-state
    always_comb begin
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    op_d     = op_i;
                    sign_a_d = start_sign_a;
                    sign_b_d = start_sign_b;
                    a_d      = start_mag_a;
                    b_d      = start_mag_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            StRun: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q[1]) begin
                    if (!rem_diff[Width]) begin
                        acc_d[2*Width-1:Width] = rem_diff[Width-1:0];
                    end else begin
                        acc_d[2*Width-1:Width] = rem_shift[Width-1:0];
                    end
                    acc_d[Width-1:0] = {acc_q[Width-2:0], ~rem_diff[Width]};
                    a_d              = {a_q[Width-2:0], 1'b0};
                end else begin
                    acc_d = mul_step;
                    b_d   = {b_q[Width-2:0], 1'b0};
                end
            end
            StFix: begin
                done_d = 1'b1;
                if (!op_q[1]) begin
                    {hi_d, lo_d} = res_neg ? prod_neg : acc_q;
                    dbz_d        = 1'b0;
                end else if (b_q == '0) begin
                    // Remainder already equals the latched dividend; skip sign fix-up.
                    hi_d  = rem;
                    lo_d  = '1;
                    dbz_d = 1'b1;
                end else begin
                    lo_d  = res_neg ? -quo : quo;
                    hi_d  = sign_a_q ? -rem : rem;
                    dbz_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dbz_q    <= dbz_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

    localparam int unsigned W = 32;
    localparam logic [1:0] OpMult  = 2'b00;
    localparam logic [1:0] OpMultu = 2'b01;
    localparam logic [1:0] OpDiv   = 2'b10;
    localparam logic [1:0] OpDivu  = 2'b11;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opa, opb;
    logic        busy, done, dbz;
    logic [31:0] hi, lo;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb[$];
    vec_t tbl[12];

    ex_muldiv_unit #(.Width(W)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .op_i         (op),
        .operand_a_i  (opa),
        .operand_b_i  (opb),
        .busy_o       (busy),
        .done_o       (done),
        .hi_o         (hi),
        .lo_o         (lo),
        .div_by_zero_o(dbz)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive a request for the coming edge, then scramble inputs to prove capture.
    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                            input bit push, input exp_t e);
        start = 1'b1;
        op    = o;
        opa   = a;
        opb   = b;
        if (push) sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = ~o;
        opa   = ~a;
        opb   = b ^ 32'h5A5A_0001;
    endtask

    task automatic wait_result(input string name);
        int   busy_cnt;
        int   lat;
        bit   got;
        exp_t e;
        busy_cnt = 0;
        lat      = 0;
        got      = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                lat = k;
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s timeout: got no done, expected done within 100 cycles", name);
            if (sb.size() > 0) void'(sb.pop_front());
        end else begin
            check({name, " latency"}, lat, W + 1);
            check({name, " busy cycles"}, busy_cnt, W + 1);
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL %s scoreboard: got done, expected none pending", name);
            end else begin
                e = sb.pop_front();
                check({name, " hi"}, hi, e.hi);
                check({name, " lo"}, lo, e.lo);
                check({name, " dbz"}, {31'b0, dbz}, {31'b0, e.dbz});
            end
            @(negedge clk);
            check({name, " done pulse"}, {31'b0, done}, 32'd0);
        end
    endtask

    task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input exp_t e);
        @(negedge clk);
        start_op(o, a, b, 1'b1, e);
        wait_result(name);
    endtask

    initial begin
        exp_t        e;
        logic [31:0] a, b;
        logic [63:0] p;
        longint      sa, sb_l;
        logic [31:0] vals[3];
        int          n_acc, n_done, n_idle;
        logic        prev_done;

        tbl[0]  = '{OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        tbl[1]  = '{OpMult,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        tbl[2]  = '{OpDiv,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        tbl[3]  = '{OpDivu,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
        tbl[4]  = '{OpDivu,  32'h0000_1234, 32'h0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
        tbl[5]  = '{OpDivu,  32'd9,         32'd3,         32'd0,         32'd3,         1'b0};
        tbl[6]  = '{OpDiv,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0};
        tbl[7]  = '{OpMult,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         1'b0};
        tbl[8]  = '{OpMultu, 32'h1234_5678, 32'h10,        32'h1,         32'h2345_6780, 1'b0};
        tbl[9]  = '{OpDiv,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
        tbl[10] = '{OpMult,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h1,         1'b0};
        tbl[11] = '{OpDivu,  32'hFFFF_FFFF, 32'd1,         32'h0,         32'hFFFF_FFFF, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        opa   = 32'h0;
        opb   = 32'h0;
        #1;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset dbz", {31'b0, dbz}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            e = '{hi: tbl[i].hi, lo: tbl[i].lo, dbz: tbl[i].dbz};
            do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, e);
        end

        // Random operands against a 64-bit arithmetic model.
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = $urandom;
            unique case (i % 3)
                0: begin
                    p = {32'b0, a} * {32'b0, b};
                    e = '{hi: p[63:32], lo: p[31:0], dbz: 1'b0};
                    do_op($sformatf("rnd%0d multu", i), OpMultu, a, b, e);
                end
                1: begin
                    b = b >> $urandom_range(0, 28);
                    if (b == 32'd0) b = 32'd1;
                    e = '{hi: a % b, lo: a / b, dbz: 1'b0};
                    do_op($sformatf("rnd%0d divu", i), OpDivu, a, b, e);
                end
                default: begin
                    sa   = longint'($signed(a));
                    sb_l = longint'($signed(b));
                    p    = 64'(sa * sb_l);
                    e    = '{hi: p[63:32], lo: p[31:0], dbz: 1'b0};
                    do_op($sformatf("rnd%0d mult", i), OpMult, a, b, e);
                end
            endcase
        end

        // Leave non-zero results so the reset clearing is observable.
        e = '{hi: 32'h0000_1234, lo: 32'hFFFF_FFFF, dbz: 1'b1};
        do_op("div0 again", OpDivu, 32'h0000_1234, 32'h0, e);

        // Reset in the middle of an op: abandoned, no done.
        @(negedge clk);
        start_op(OpMultu, 32'd5, 32'd6, 1'b0, e);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset busy", {31'b0, busy}, 32'd0);
        check("midreset done", {31'b0, done}, 32'd0);
        check("midreset hi", hi, 32'd0);
        check("midreset lo", lo, 32'd0);
        check("midreset dbz", {31'b0, dbz}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        e = '{hi: 32'd0, lo: 32'd56, dbz: 1'b0};
        start_op(OpMultu, 32'd7, 32'd8, 1'b1, e);
        wait_result("post-reset");

        // start_i held high: back-to-back ops, each with its own start-edge operand.
        vals[0] = 32'h0000_0011;
        vals[1] = 32'hF000_0000;
        vals[2] = 32'h0000_ABCD;
        @(negedge clk);
        start = 1'b1;
        op    = OpMultu;
        opb   = 32'd3;
        opa   = vals[0];
        p     = {32'b0, vals[0]} * 64'd3;
        sb.push_back('{hi: p[63:32], lo: p[31:0], dbz: 1'b0});
        @(posedge clk);
        #1;
        n_acc = 1;
        opa   = vals[1];
        p     = {32'b0, vals[1]} * 64'd3;
        sb.push_back('{hi: p[63:32], lo: p[31:0], dbz: 1'b0});
        n_done    = 0;
        n_idle    = 0;
        prev_done = 1'b0;
        for (int k = 0; k < 200 && n_done < 3; k++) begin
            @(negedge clk);
            if (done) begin
                check("b2b done gap", {31'b0, prev_done}, 32'd0);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check($sformatf("b2b%0d hi", n_done), hi, e.hi);
                    check($sformatf("b2b%0d lo", n_done), lo, e.lo);
                end
                n_done++;
            end
            prev_done = done;
            if (!busy) begin
                n_idle++;
                check("b2b idle is done cycle", {31'b0, done}, 32'd1);
                if (start) begin
                    @(posedge clk);
                    #1;
                    n_acc++;
                    if (n_acc < 3) begin
                        opa = vals[n_acc];
                        p   = {32'b0, vals[n_acc]} * 64'd3;
                        sb.push_back('{hi: p[63:32], lo: p[31:0], dbz: 1'b0});
                    end else begin
                        start = 1'b0;
                    end
                end
            end
        end
        check("b2b done count", n_done, 32'd3);
        check("b2b idle count", n_idle, 32'd3);
        check("scoreboard empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
